// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch front end.
//   Word      : instruction / address width
//   Nop       : instruction presented when no head is valid
//   align_word: clears the byte-offset bits of an address
package if_prefetch_pkg;

  localparam int unsigned Word = 32;
  localparam logic [Word-1:0] Nop = '0;

  function automatic logic [Word-1:0] align_word(input logic [Word-1:0] addr);
    return {addr[Word-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Small in-order FIFO used for the instruction+PC queue and the PC tag queue.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   clear_i      : drop all contents (same effect as reset, takes priority over push/pop)
//   push_i/wdata_i : write an entry (ignored when full)
//   pop_i        : retire the head (ignored when empty)
//   rdata_o      : head entry (only meaningful when !empty_o)
//   count_o, full_o, empty_o : occupancy
module prefetch_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_en, pop_en;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_en) wptr_q <= wptr_q + 1'b1;
      if (pop_en)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CntW'(push_en) - CntW'(pop_en);
    end
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk_i) begin
    if (push_en && !clear_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction prefetch front end feeding the IF/ID register.
// Issues sequential fetches to a variable-latency memory, queues returned words with
// their PCs, and presents one instruction per cycle. Redirect flushes the queue and
// discards every response still in flight.
// Ports:
//   clk_i, rst_i               : clock, synchronous active-high reset
//   stall_i                    : hold the head (no consume)
//   redirect_i, redirect_pc_i  : taken branch/jump and its target
//   imem_req_o, imem_addr_o, imem_ready_i         : request handshake
//   imem_rvalid_i, imem_rdata_i                   : in-order responses
//   inst_valid_o, instruction_o, pc_o             : queue head (zeros when invalid)
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int unsigned     Depth   = 4,
  parameter logic [Word-1:0] ResetPc = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [Word-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [Word-1:0] imem_addr_o,
  input  logic            imem_ready_i,
  input  logic            imem_rvalid_i,
  input  logic [Word-1:0] imem_rdata_i,
  output logic            inst_valid_o,
  output logic [Word-1:0] instruction_o,
  output logic [Word-1:0] pc_o
);

  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic [Word-1:0] fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;

  logic [CntW:0]   committed;
  logic            accept, drop_resp, iq_push, iq_pop;
  logic [2*Word-1:0] iq_rdata;
  logic [CntW-1:0] iq_count, tag_count;
  logic            iq_full, iq_empty, tag_full, tag_empty;
  logic [Word-1:0] tag_pc;

  // Credits: every in-flight request must have a guaranteed queue slot.
  assign committed   = {1'b0, outstanding_q} + {1'b0, iq_count};
  assign imem_req_o  = !rst_i && !redirect_i && (committed < (CntW+1)'(Depth));
  assign imem_addr_o = fetch_pc_q;
  assign accept      = imem_req_o && imem_ready_i;

  assign drop_resp = (drop_cnt_q != '0);
  assign iq_push   = imem_rvalid_i && !drop_resp && !redirect_i;
  assign iq_pop    = !iq_empty && !stall_i && !redirect_i;

  // Tags are not flushed on redirect: dropped responses still pop their own tag.
  prefetch_fifo #(
    .Width (Word),
    .Depth (Depth)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (1'b0),
    .push_i  (accept),
    .wdata_i (fetch_pc_q),
    .pop_i   (imem_rvalid_i),
    .rdata_o (tag_pc),
    .count_o (tag_count),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  prefetch_fifo #(
    .Width (2 * Word),
    .Depth (Depth)
  ) u_inst_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (redirect_i),
    .push_i  (iq_push),
    .wdata_i ({tag_pc, imem_rdata_i}),
    .pop_i   (iq_pop),
    .rdata_o (iq_rdata),
    .count_o (iq_count),
    .full_o  (iq_full),
    .empty_o (iq_empty)
  );

  always_comb begin
    outstanding_d = outstanding_q + CntW'(accept) - CntW'(imem_rvalid_i);
    drop_cnt_d    = drop_cnt_q - CntW'(imem_rvalid_i && drop_resp);
    fetch_pc_d    = accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
    if (redirect_i) begin
      // Everything still in flight after this cycle belongs to the old path.
      drop_cnt_d = outstanding_q - CntW'(imem_rvalid_i);
      fetch_pc_d = align_word(redirect_pc_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q    <= ResetPc;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign inst_valid_o  = !iq_empty;
  assign instruction_o = iq_empty ? Nop : iq_rdata[Word-1:0];
  assign pc_o          = iq_empty ? '0 : iq_rdata[2*Word-1:Word];

  logic unused_tag_state;
  assign unused_tag_state = ^{tag_count, tag_full};

  // A kept response arriving with the queue full means the memory broke the credit rule.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) iq_push |-> !iq_full);
  a_tag_present: assert property (@(posedge clk_i) disable iff (rst_i)
                                  imem_rvalid_i |-> !tag_empty);

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Instruction prefetch front end sitting directly upstream of the IF/ID pipeline register. It issues sequential fetch requests to a variable-latency instruction memory, buffers returned words with their PCs in a small in-order queue, and presents one instruction per cycle to IF/ID. It honours the ID-stage `stall` (freeze) and `branch_taken | jump_taken` (redirect), discarding queued and in-flight words on redirect.

## Interface
- `DEPTH`, 4: queue entries and maximum outstanding requests; power of two, 2..16.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  IF/ID freeze; head is held, not consumed.
- `redirect`  in  1  branch_taken | jump_taken from ID.
- `redirect_pc`  in  `WORD`  new fetch address, valid with `redirect`.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  `WORD`  fetch address, word aligned.
- `imem_ready`  in  1  memory accepts the request this cycle.
- `imem_rvalid`  in  1  response word valid, in request order, at least 1 cycle after acceptance.
- `imem_rdata`  in  `WORD`  response instruction.
- `inst_valid`  out  1  queue head valid.
- `instruction`  out  `WORD`  head instruction; `NOP` (32'h0) when `inst_valid`=0.
- `pc`  out  `WORD`  head PC; 0 when `inst_valid`=0.

## Operation
- State: `fetch_pc`, `outstanding` (0..DEPTH), `drop_cnt` (0..DEPTH), queue `count` (0..DEPTH), read/write pointers; all counters `$clog2(DEPTH)+1` bits, pointers `$clog2(DEPTH)` bits, wrap modulo DEPTH.
- Request: `imem_req` = !rst && !redirect && (outstanding + count < DEPTH). `imem_addr` = `fetch_pc`. Accept = `imem_req && imem_ready`; on accept `fetch_pc += 4` (wraps at 2^32).
- Each accepted request carries its PC in a side FIFO of DEPTH entries (PC tag queue); pushed on accept, popped on `imem_rvalid`.
- Response: if `drop_cnt` > 0, word discarded and `drop_cnt` decrements; else word + popped PC written into queue. Credit rule guarantees queue never overflows; a response arriving with `count`=DEPTH is a protocol error (assertion).
- `outstanding` next = outstanding + accept − rvalid.
- Consume: head popped when `inst_valid && !stall && !redirect`.
- Redirect (priority over everything): queue cleared (count=0, pointers reset), `fetch_pc` <= `redirect_pc`, `drop_cnt` <= `outstanding − imem_rvalid` + 0 (all still-in-flight responses dropped); any response in the redirect cycle is discarded; no request issued, no consume.
- `stall` and `redirect` together: redirect wins (matches IF/ID flush-over-freeze).
- Misaligned `redirect_pc`: low two bits forced to 0.

## Timing
- Reset: `imem_req`=0, `inst_valid`=0, `instruction`=0, `pc`=0, `fetch_pc`=RESET_PC, all counters 0. First request asserted the cycle after `rst` drops.
- Outputs `inst_valid`/`instruction`/`pc` are driven from registered queue state only (no combinational path from `imem_rdata`).
- Best-case latency: request accepted cycle N, response N+1, head visible N+2.
- Steady state with 1-cycle memory and no stall: one instruction per cycle after a 2-cycle fill.
- After redirect in cycle R: new request at `redirect_pc` issued cycle R+1 (if credits allow, i.e. outstanding − drops resolve); first redirected instruction at head no earlier than R+3.
- Reset mid-operation: all state returns to reset values next edge; late memory responses after reset are not discarded (memory is reset with the core).

## Structure
- `WORD`, `NOP` (32'h0) come from `constants.v`; no new shared constants.
- One sub-module: `prefetch_fifo` (parameterised WIDTH/DEPTH, push/pop/clear, count, full/empty), instantiated twice: instruction+PC queue (WIDTH=2*WORD) and PC tag queue (WIDTH=WORD).

## Test plan
- Reset, 1-cycle memory returning addr as data, no stall -> `imem_addr` 0,4,8,…; `inst_valid` from cycle 2; `pc`/`instruction` 0,4,8 on consecutive cycles.
- `stall` held 6 cycles with DEPTH=4 -> `imem_req` drops after 4 outstanding+queued; head stays pc=0; release -> pc 4,8,12 then fetching resumes with no gap or duplicate.
- Memory latency 3, redirect to 0x100 while 3 requests in flight -> 3 responses discarded, queue empty, next head pc=0x100.
- Redirect in same cycle as a response and `stall`=1 -> response dropped, no consume, `drop_cnt` = outstanding−1, first head pc = redirect_pc.
- `imem_ready` toggling 1/0 pseudo-randomly, random latency 1–5 -> head PCs strictly sequential, no loss, `outstanding + count` ≤ DEPTH every cycle.
- `rst` asserted mid-fetch with 2 words queued -> next cycle `inst_valid`=0, `imem_req`=0, then fetch restarts at RESET_PC.
